sync_req_arbiter: RTL and testbench

//  Round-robin arbiter granting one shared registered resource (flop-gated datapath) to N_REQ requesters.

---
 rtl/sync_req_arbiter.sv | 147 ++++++++++++++
 tb/tb_sync_req_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter for one shared gated datapath: requests are synchronized into d_clk,
// a grant is held while its request stays high, and a watchdog revokes grants held too long.
module sync_req_arbiter #(
  parameter int N_REQ       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_HOLD    = 16
) (
  input  logic                     d_clk,
  input  logic                     d_rst_n,
  input  logic [N_REQ-1:0]         req_async,
  input  logic                     enable,
  output logic [N_REQ-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     timeout
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0][N_REQ-1:0] sync_q;
  logic [N_REQ-1:0]         req_sync;
  logic [N_REQ-1:0]         block_q, block_d;
  logic [N_REQ-1:0]         eligible;
  logic [N_REQ-1:0]         grant_d;
  logic [ID_W-1:0]          grant_id_d;
  logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]          pick_idx, scan_idx;
  logic                     pick_found;
  logic [CNT_W-1:0]         hold_q, hold_d;
  logic                     timeout_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    return (v == ID_LAST) ? '0 : v + 1'b1;
  endfunction

  // synchronizer stage boundary: only the last stage is visible to arbitration
  always_ff @(posedge d_clk or negedge d_rst_n) begin
    if (!d_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= req_async;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign req_sync = sync_q[SYNC_STAGES-1];
  assign eligible = req_sync & ~block_q;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!pick_found && eligible[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant;
    grant_id_d = grant_id;
    hold_d     = hold_q;
    timeout_d  = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    // a block lifts as soon as its synchronized request is seen low
    block_d    = block_q & req_sync;
    case (state_q)
      S_IDLE: begin
        if (enable && pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          grant_id_d        = pick_idx;
          hold_d            = '0;
          state_d           = S_GRANT;
        end
      end
      S_GRANT: begin
        hold_d = sat_inc(hold_q);
        if (!req_sync[grant_id]) begin
          grant_d = '0;
          state_d = S_RELEASE;
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST)) begin
          grant_d           = '0;
          timeout_d         = 1'b1;
          block_d[grant_id] = 1'b1;
          state_d           = S_RELEASE;
        end
      end
      S_RELEASE: begin
        grant_d  = '0;
        rr_ptr_d = wrap_inc(grant_id);
        state_d  = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // arbitration state boundary: all outputs except busy are registered here
  always_ff @(posedge d_clk or negedge d_rst_n) begin
    if (!d_rst_n) begin
      state_q     <= S_IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout     <= 1'b0;
      hold_q      <= '0;
      block_q     <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant       <= grant_d;
      grant_valid <= |grant_d;
      grant_id    <= grant_id_d;
      timeout     <= timeout_d;
      hold_q      <= hold_d;
      block_q     <= block_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_sync_req_arbiter.sv
// Self-checking bench for sync_req_arbiter: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the arbitration rules.
module tb_sync_req_arbiter;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int MH = 8;

  logic       d_clk = 1'b0;
  logic       d_rst_n;
  logic [3:0] req_async;
  logic       enable;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  int vectors     = 0;
  int miscompares = 0;

  // behavioural model state
  logic [3:0] m_hist [S];
  logic [3:0] m_grant;
  logic [3:0] m_block;
  logic       m_timeout;
  int         m_phase;   // 0 idle, 1 granted, 2 dead cycle
  int         m_id;
  int         m_held;
  int         m_ptr;

  logic [8:0] obs_v;

  sync_req_arbiter #(
    .N_REQ(N),
    .SYNC_STAGES(S),
    .MAX_HOLD(MH)
  ) dut (
    .d_clk(d_clk),
    .d_rst_n(d_rst_n),
    .req_async(req_async),
    .enable(enable),
    .grant(grant),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .busy(busy),
    .timeout(timeout)
  );

  always #5 d_clk = ~d_clk;

  assign obs_v = {grant, grant_valid, grant_id, busy, timeout};

  function automatic logic [8:0] model_out();
    return {m_grant, (m_grant != 4'b0000), 2'(m_id), (m_phase != 0), m_timeout};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < S; i++) m_hist[i] = 4'b0000;
    m_grant   = 4'b0000;
    m_block   = 4'b0000;
    m_timeout = 1'b0;
    m_phase   = 0;
    m_id      = 0;
    m_held    = 0;
    m_ptr     = 0;
  endtask

  // advance one clock: model sees the inputs present at the edge, returns at the negedge
  task automatic step();
    logic [3:0] rs;
    logic [3:0] elig;
    int         w;
    @(posedge d_clk);
    if (!d_rst_n) begin
      model_reset();
    end else begin
      rs        = m_hist[S-1];
      elig      = rs & ~m_block;
      m_timeout = 1'b0;
      case (m_phase)
        0: begin
          if (enable && elig != 4'b0000) begin
            w = m_ptr;
            while (!elig[w]) w = (w + 1) % N;
            m_grant = 4'b0001 << w;
            m_id    = w;
            m_held  = 1;
            m_phase = 1;
          end
        end
        1: begin
          if (!rs[m_id]) begin
            m_grant = 4'b0000;
            m_phase = 2;
          end else if (m_held == MH) begin
            m_grant   = 4'b0000;
            m_timeout = 1'b1;
            m_phase   = 2;
          end else begin
            m_held++;
          end
        end
        default: begin
          m_ptr   = (m_id + 1) % N;
          m_phase = 0;
        end
      endcase
      m_block = m_block & rs;
      if (m_timeout) m_block[m_id] = 1'b1;
      for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = req_async;
    end
    @(negedge d_clk);
  endtask

  task automatic apply_reset();
    d_rst_n = 1'b0;
    model_reset();
    #1;
    d_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    d_rst_n   = 1'b0;
    req_async = 4'hF;
    enable    = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (obs_v !== 9'h000) begin
      miscompares++;
      $display("FAIL reset_t0: got %h expected %h", obs_v, 9'h000);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      vectors++;
      if (obs_v !== 9'h000) begin
        miscompares++;
        $display("FAIL reset_hold c%0d: got %h expected %h", c, obs_v, 9'h000);
      end
    end
    req_async = 4'h0;
    d_rst_n   = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_single();
    req_async = 4'b0100;
    for (int c = 1; c <= 10; c++) begin
      if (c == 7) req_async = 4'b0000;
      step();
      vectors++;
      if (obs_v !== model_out()) begin
        miscompares++;
        $display("FAIL single c%0d: got %h expected %h", c, obs_v, model_out());
      end
      if (c == 3) begin
        vectors++;
        if (grant !== 4'b0100 || grant_id !== 2'd2) begin
          miscompares++;
          $display("FAIL single_grant: got grant=%b id=%0d expected grant=0100 id=2", grant, grant_id);
        end
      end
      if (c == 9) begin
        vectors++;
        if (grant !== 4'b0000 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL single_release: got grant=%b busy=%b expected grant=0000 busy=1", grant, busy);
        end
      end
      if (c == 10) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL single_idle: got busy=%b expected 0", busy);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int   order[$];
    int   since[4];
    bit   active[4];
    logic prev_v;
    int   exp_order[5];
    exp_order = '{0, 1, 3, 0, 3};
    prev_v    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      since[i]  = 0;
      active[i] = 1'b0;
    end
    apply_reset();
    req_async = 4'b1011;
    for (int c = 1; c <= 60; c++) begin
      if (c == 30) req_async = 4'b1001;
      step();
      vectors++;
      if (obs_v !== model_out() || !$onehot0(grant)) begin
        miscompares++;
        $display("FAIL rr c%0d: got %h expected %h", c, obs_v, model_out());
      end
      if (grant_valid && !prev_v) begin
        order.push_back(int'(grant_id));
        since[grant_id]  = 0;
        active[grant_id] = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (active[i]) begin
            since[i]++;
            if (since[i] == 2) begin
              req_async[i] = 1'b0;
              active[i]    = 1'b0;
            end
          end
        end
      end
      prev_v = grant_valid;
    end
    vectors++;
    if (order.size() != 5) begin
      miscompares++;
      $display("FAIL rr_count: got %0d grants expected 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (order[i] != exp_order[i]) begin
          miscompares++;
          $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_watchdog();
    int g1, g1_after, to_cnt, g2, regrant;
    bit timed_out;
    g1 = 0; g1_after = 0; to_cnt = 0; g2 = 0; regrant = 0; timed_out = 1'b0;
    req_async = 4'b0010;
    for (int c = 1; c <= 30; c++) begin
      if (c == 3)  req_async[2] = 1'b1;
      if (c == 16) req_async[2] = 1'b0;
      step();
      vectors++;
      if (obs_v !== model_out()) begin
        miscompares++;
        $display("FAIL wdog c%0d: got %h expected %h", c, obs_v, model_out());
      end
      if (grant[1] && !timed_out) g1++;
      if (grant[1] && timed_out) g1_after++;
      if (timeout) begin
        to_cnt++;
        timed_out = 1'b1;
      end
      if (grant == 4'b0100) g2++;
    end
    vectors++;
    if (g1 != 8 || to_cnt != 1) begin
      miscompares++;
      $display("FAIL wdog_len: got hold=%0d pulses=%0d expected hold=8 pulses=1", g1, to_cnt);
    end
    vectors++;
    if (g2 != 5 || g1_after != 0) begin
      miscompares++;
      $display("FAIL wdog_next: got g2=%0d regrant1=%0d expected g2=5 regrant1=0", g2, g1_after);
    end
    req_async = 4'b0000;
    repeat (3) step();
    req_async = 4'b0010;
    for (int c = 1; c <= 8; c++) begin
      step();
      vectors++;
      if (obs_v !== model_out()) begin
        miscompares++;
        $display("FAIL wdog_re c%0d: got %h expected %h", c, obs_v, model_out());
      end
      if (grant[1]) regrant++;
    end
    vectors++;
    if (regrant == 0) begin
      miscompares++;
      $display("FAIL wdog_reassert: got no grant for requester 1 expected a grant");
    end
    req_async = 4'b0000;
    repeat (5) step();
  endtask

  task automatic test_enable();
    enable    = 1'b0;
    req_async = 4'b0001;
    for (int c = 1; c <= 10; c++) begin
      step();
      vectors++;
      if (obs_v !== model_out() || grant !== 4'b0000) begin
        miscompares++;
        $display("FAIL en_off c%0d: got %h expected %h", c, obs_v, model_out());
      end
    end
    enable = 1'b1;
    step();
    vectors++;
    if (grant !== 4'b0001 || obs_v !== model_out()) begin
      miscompares++;
      $display("FAIL en_on: got grant=%b expected 0001", grant);
    end
    enable = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      vectors++;
      if (grant !== 4'b0001 || obs_v !== model_out()) begin
        miscompares++;
        $display("FAIL en_hold c%0d: got grant=%b expected 0001", c, grant);
      end
    end
    req_async = 4'b0000;
    for (int c = 1; c <= 4; c++) begin
      step();
      vectors++;
      if (obs_v !== model_out()) begin
        miscompares++;
        $display("FAIL en_drop c%0d: got %h expected %h", c, obs_v, model_out());
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_async_reset();
    bit seen;
    seen      = 1'b0;
    req_async = 4'b1000;
    for (int c = 1; c <= 10 && !seen; c++) begin
      step();
      if (grant == 4'b1000) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL arst_grant: got grant=%b expected 1000 within 10 cycles", grant);
    end
    step();
    #2;
    d_rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (obs_v !== 9'h000) begin
      miscompares++;
      $display("FAIL arst_drop: got %h expected %h", obs_v, 9'h000);
    end
    step();
    step();
    d_rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      vectors++;
      if (obs_v !== model_out()) begin
        miscompares++;
        $display("FAIL arst_re c%0d: got %h expected %h", c, obs_v, model_out());
      end
      if (c == 3) begin
        vectors++;
        if (grant !== 4'b1000 || grant_id !== 2'd3) begin
          miscompares++;
          $display("FAIL arst_regrant: got grant=%b id=%0d expected grant=1000 id=3", grant, grant_id);
        end
      end
    end
    req_async = 4'b0000;
    repeat (5) step();
  endtask

  task automatic test_random();
    apply_reset();
    req_async = 4'b0000;
    enable    = 1'b1;
    for (int c = 1; c <= 500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) req_async[i] = ~req_async[i];
      end
      enable = ($urandom_range(0, 9) != 0);
      step();
      vectors++;
      if (obs_v !== model_out() || !$onehot0(grant)) begin
        miscompares++;
        $display("FAIL random c%0d: got %h expected %h", c, obs_v, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_watchdog();
    test_enable();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL time_limit: simulation did not finish within 200us");
    $fatal(1);
  end

endmodule
